mailbox: RTL
============

# mailbox

Receive-side message buffer between the loopback interceptor and the core's receive unit. Holds up to DEPTH received messages in arrival order. Delivers the oldest message to the core, or the oldest message from a chosen sender when filtering is enabled, and compacts the queue after each removal. Provides the backpressure that the loopback interceptor forwards to both the interface and the local post office.

## Interface

Parameters:
- DEPTH, 4: number of message slots. Must be at least 2.
- COUNT_WIDTH, $clog2(DEPTH+1): width of the occupancy output.

Ports:
- clk  input  1  clock.
- rst  input  1  reset. Synchronous and active-high; it is applied on the rising edge of clk.
- loopback_mailbox_valid  input  1  incoming message valid.
- mailbox_loopback_ready  output  1  a free slot exists.
- loopback_mailbox_data  input  interface_receive_data_t  incoming message; message.meta.address holds the sender.
- mailbox_receiver_valid  output  1  a message matching the current filter is available.
- receiver_mailbox_ready  input  1  the receive unit takes the presented message.
- mailbox_receiver_data  output  interface_receive_data_t  selected message.
- receiver_mailbox_filter_enable  input  1  when 1, only messages from filter_address are eligible.
- receiver_mailbox_filter_address  input  message_addr_t  sender to match.
- mailbox_count  output  COUNT_WIDTH  number of occupied slots.
- mailbox_empty  output  1  mailbox_count == 0.

## Operation

- Storage is slots 0..DEPTH-1 with a per-slot valid bit. Slot 0 is the oldest.
- Occupied slots are always contiguous from slot 0. There are no holes.
- Push:
  - A push occurs when loopback_mailbox_valid && mailbox_loopback_ready.
  - The message is written to slot mailbox_count, or to slot mailbox_count-1 when a pop happens in the same cycle.
- Selection:
  - sel is the lowest occupied slot index i for which filter_enable==0 || slot[i].message.meta.address == filter_address.
  - Selection is combinational from stored slots and the current filter inputs.
  - mailbox_receiver_valid = a sel exists. mailbox_receiver_data = slot[sel]. When nothing matches, data is slot 0 and is don't-care.
- Pop:
  - A pop occurs when mailbox_receiver_valid && receiver_mailbox_ready.
  - Slot sel is removed. Every slot above sel shifts down by one, which keeps the remaining messages in arrival order.
- Simultaneous push and pop: the shift and the append happen in the same cycle, and the count is unchanged.
- mailbox_loopback_ready = (mailbox_count < DEPTH). It depends only on registered state.
  - No push is accepted while full, even if a pop happens in the same cycle.
  - There is no combinational path from receiver ready to upstream ready.
- A message pushed in cycle N is not visible to selection before cycle N+1. There is no bypass.
- The filter inputs may change in any cycle. The selection follows them combinationally.
- Non-matching messages stay in the mailbox indefinitely. The block does not time them out or drop them.

## Timing

- Reset values:
  - all slot valid bits = 0.
  - mailbox_count = 0.
  - mailbox_empty = 1.
  - mailbox_loopback_ready = 1.
  - mailbox_receiver_valid = 0.
  - Slot data is not reset.
- Reset mid-operation discards all stored messages. No handshake is honoured in the reset cycle.
- Latency is one cycle from accepted push to mailbox_receiver_valid, when the message matches.
- Throughput is one push and one pop per cycle in steady state, with no bubbles except while full.
- mailbox_count updates on the clock edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- Once asserted, mailbox_receiver_valid with fixed filter inputs remains asserted until a pop occurs.
- The selected data remains stable until a pop occurs.

## Structure

- Use the existing xctcmsg_pkg types interface_receive_data_t and message_addr_t. No new package types are required.
- Add MAILBOX_DEPTH (default 4) to xctcmsg_pkg so that top-level instantiation and the receive unit agree on capacity.
- One sub-module, mailbox_match_select: a combinational priority encoder that takes the per-slot valid bits, the sender addresses and the filter, and produces sel and the valid flag. It is unit-testable on its own.
- The shift/append datapath and the counter live in mailbox.

## Test plan

1. Reset, then push senders 3, 5, 7 with no filter and receiver ready held low.
   - count = 3 and ready = 1.
   - Raising ready pops 3, then 5, then 7 on consecutive cycles.
   - count returns to 0 and empty = 1.
2. Fill with DEPTH=4 messages from senders 1, 2, 1, 4.
   - ready drops to 0 and a fifth valid is not accepted.
   - With filter on and address 1, the receiver gets slot 0 and then the old slot 2.
   - Afterwards the slots hold senders 2 and 4 in order, and count = 2.
3. Mailbox full, with a pop and an upstream valid in the same cycle.
   - The pop completes and the push is refused.
   - Next cycle: ready = 1 and count = 3.
4. Mailbox holds 2 messages, with a push and a pop in the same cycle.
   - count stays 2.
   - The new message lands in slot 1 behind the surviving message.
5. Filter on, address 6, with no sender-6 message stored. Then push one from sender 6.
   - receiver_valid is 0 until exactly one cycle after that push is accepted, then 1 with the sender-6 data.
6. Assert rst with 3 stored messages and a handshake active in the same cycle.
   - Next cycle: count = 0, empty = 1, receiver_valid = 0 and ready = 1.
   - The message pushed in the reset cycle is not stored.

Source files
------------

// File: rtl/xctcmsg_pkg.sv
// Shared message types for the receive path, plus the mailbox capacity that the
// top level and the receive unit must agree on.
package xctcmsg_pkg;

  localparam int MAILBOX_DEPTH = 4;
  localparam int ADDR_WIDTH    = 4;
  localparam int PAYLOAD_WIDTH = 16;

  typedef logic [ADDR_WIDTH-1:0] message_addr_t;

  typedef struct packed {
    message_addr_t address;
  } message_meta_t;

  typedef struct packed {
    message_meta_t            meta;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } message_t;

  typedef struct packed {
    message_t message;
  } interface_receive_data_t;

endpackage

// File: rtl/mailbox_match_select.sv
// Picks the lowest occupied slot whose sender passes the filter; purely combinational.
// No state and no handshake, so latency and backpressure belong to the caller.
module mailbox_match_select
  import xctcmsg_pkg::*;
#(
  parameter int DEPTH = MAILBOX_DEPTH,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] slot_valid,
  input  message_addr_t    slot_address [DEPTH],
  input  logic             filter_enable,
  input  message_addr_t    filter_address,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid
);

  // Walking downwards lets the lowest matching index win; no match leaves sel at slot 0.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (slot_valid[i] && (!filter_enable || slot_address[i] == filter_address)) begin
        sel       = SEL_W'(i);
        sel_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mailbox.sv
// Arrival-ordered receive buffer with optional sender filter; push visible to the
// receiver one cycle later, ready drops only on a full registered count.
module mailbox
  import xctcmsg_pkg::*;
#(
  parameter int DEPTH       = MAILBOX_DEPTH,
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    loopback_mailbox_valid,
  output logic                    mailbox_loopback_ready,
  input  interface_receive_data_t loopback_mailbox_data,
  output logic                    mailbox_receiver_valid,
  input  logic                    receiver_mailbox_ready,
  output interface_receive_data_t mailbox_receiver_data,
  input  logic                    receiver_mailbox_filter_enable,
  input  message_addr_t           receiver_mailbox_filter_address,
  output logic [COUNT_WIDTH-1:0]  mailbox_count,
  output logic                    mailbox_empty
);

  localparam int SEL_W = $clog2(DEPTH);

  interface_receive_data_t slot_dat [DEPTH];
  logic [DEPTH-1:0]        slot_vld;
  logic [COUNT_WIDTH-1:0]  count;

  message_addr_t           slot_address [DEPTH];
  logic [SEL_W-1:0]        sel;
  logic                    sel_vld;
  logic                    push;
  logic                    pop;
  logic [COUNT_WIDTH-1:0]  wr_idx;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_address[i] = slot_dat[i].message.meta.address;
    end
  end

  mailbox_match_select #(
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_match_select (
    .slot_valid     (slot_vld),
    .slot_address   (slot_address),
    .filter_enable  (receiver_mailbox_filter_enable),
    .filter_address (receiver_mailbox_filter_address),
    .sel            (sel),
    .sel_valid      (sel_vld)
  );

  // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
  assign mailbox_loopback_ready = (count < COUNT_WIDTH'(DEPTH));
  assign mailbox_receiver_valid = sel_vld;
  assign mailbox_receiver_data  = slot_dat[sel];
  assign mailbox_count          = count;
  assign mailbox_empty          = (count == '0);

  assign push   = loopback_mailbox_valid && mailbox_loopback_ready;
  assign pop    = sel_vld && receiver_mailbox_ready;
  assign wr_idx = pop ? count - 1'b1 : count;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld <= '0;
      count    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pop && SEL_W'(i) >= sel) begin
          slot_vld[i] <= (i < DEPTH - 1) ? slot_vld[(i + 1) % DEPTH] : 1'b0;
        end
        if (push && wr_idx == COUNT_WIDTH'(i)) begin
          slot_vld[i] <= 1'b1;
        end
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Payload storage carries no reset; validity alone decides what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (pop && SEL_W'(i) >= sel && i < DEPTH - 1) begin
        slot_dat[i] <= slot_dat[(i + 1) % DEPTH];
      end
      if (push && wr_idx == COUNT_WIDTH'(i)) begin
        slot_dat[i] <= loopback_mailbox_data;
      end
    end
  end

endmodule
